// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: turns load-use hazards, taken branches and halt requests
// into PC / IF-ID / ID-EX controls, and keeps saturating performance counters.
module pipeline_hazard_controller #(
  parameter int CNT_W    = 16,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [1:0]       id_rs1,
  input  logic [1:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [1:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_reg_write,
  input  logic             mem_valid,
  input  logic             ex_branch_taken,
  input  logic             wb_retire,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             stall,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       STALL_INI = 2'(LOAD_LAT - 1);

  state_t     state_q, state_d;
  logic [1:0] stall_left_q, stall_left_d;
  logic       hz;
  logic       flush_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  assign hz = id_valid & ex_valid & ex_is_load & ex_reg_write &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  assign state = state_q;

  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    stall        = 1'b0;
    halted       = 1'b0;
    flush_evt    = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_evt    = 1'b1;
        end else if (hz) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          stall        = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d      = LDSTALL;
            stall_left_d = STALL_INI;
          end
        end else if (halt_req) begin
          state_d = DRAIN;
        end
      end
      LDSTALL: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        stall        = 1'b1;
        stall_left_d = stall_left_q - 2'd1;
        if (stall_left_q == 2'd1) state_d = RUN;
      end
      DRAIN: begin
        // Fetch is squashed; the instruction already in ID is allowed through.
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        if (ex_branch_taken) begin
          id_ex_bubble = 1'b1;
          flush_evt    = 1'b1;
        end else if (hz) begin
          if_id_flush  = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          stall        = 1'b1;
        end
        if (!id_valid && !ex_valid && !mem_valid) state_d = HALTED;
      end
      HALTED: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        halted       = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      stall        = 1'b0;
      halted       = 1'b0;
      flush_evt    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      stall_left_q <= 2'd0;
      cycle_cnt    <= '0;
      retire_cnt   <= '0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
      if (cnt_clr) begin
        cycle_cnt  <= '0;
        retire_cnt <= '0;
        stall_cnt  <= '0;
        flush_cnt  <= '0;
      end else begin
        cycle_cnt  <= sat_inc(cycle_cnt, state_q != HALTED);
        retire_cnt <= sat_inc(retire_cnt, wb_retire);
        stall_cnt  <= sat_inc(stall_cnt, stall);
        flush_cnt  <= sat_inc(flush_cnt, flush_evt);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: two controller instances (LOAD_LAT=1/CNT_W=16 and
// LOAD_LAT=3/CNT_W=4) share stimulus and are checked against a cycle model.
module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic       reset;
    logic       id_valid;
    logic [1:0] id_rs1;
    logic [1:0] id_rs2;
    logic       u1;
    logic       u2;
    logic       ex_valid;
    logic [1:0] ex_rd;
    logic       ex_is_load;
    logic       ex_reg_write;
    logic       mem_valid;
    logic       br;
    logic       retire;
    logic       halt;
    logic       clr;
  } stim_t;

  typedef struct {
    int mode;   // 0 run, 1 load stall, 2 drain, 3 halted
    int rem;    // load-stall cycles still owed
    int cyc, ret, stl, fl;
    bit known;
  } mst_t;

  typedef struct {
    logic pc_en, if_id_en, flush, bubble, stall, halted;
    int   state, cyc, ret, stl, fl;
    bit   chk;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t s;
  int errors = 0;
  int checks = 0;
  exp_t qa[$];
  exp_t qb[$];
  mst_t ma, mb;

  logic        a_pc, a_en, a_fl, a_bub, a_st, a_h;
  logic [1:0]  a_state;
  logic [15:0] a_cyc, a_ret, a_stl, a_flc;
  logic        b_pc, b_en, b_fl, b_bub, b_st, b_h;
  logic [1:0]  b_state;
  logic [3:0]  b_cyc, b_ret, b_stl, b_flc;

  pipeline_hazard_controller #(.CNT_W(16), .LOAD_LAT(1)) dut_a (
    .clk(clk), .reset(s.reset), .id_valid(s.id_valid), .id_rs1(s.id_rs1), .id_rs2(s.id_rs2),
    .id_uses_rs1(s.u1), .id_uses_rs2(s.u2), .ex_valid(s.ex_valid), .ex_rd(s.ex_rd),
    .ex_is_load(s.ex_is_load), .ex_reg_write(s.ex_reg_write), .mem_valid(s.mem_valid),
    .ex_branch_taken(s.br), .wb_retire(s.retire), .halt_req(s.halt), .cnt_clr(s.clr),
    .pc_en(a_pc), .if_id_en(a_en), .if_id_flush(a_fl), .id_ex_bubble(a_bub), .stall(a_st),
    .halted(a_h), .state(a_state), .cycle_cnt(a_cyc), .retire_cnt(a_ret),
    .stall_cnt(a_stl), .flush_cnt(a_flc));

  pipeline_hazard_controller #(.CNT_W(4), .LOAD_LAT(3)) dut_b (
    .clk(clk), .reset(s.reset), .id_valid(s.id_valid), .id_rs1(s.id_rs1), .id_rs2(s.id_rs2),
    .id_uses_rs1(s.u1), .id_uses_rs2(s.u2), .ex_valid(s.ex_valid), .ex_rd(s.ex_rd),
    .ex_is_load(s.ex_is_load), .ex_reg_write(s.ex_reg_write), .mem_valid(s.mem_valid),
    .ex_branch_taken(s.br), .wb_retire(s.retire), .halt_req(s.halt), .cnt_clr(s.clr),
    .pc_en(b_pc), .if_id_en(b_en), .if_id_flush(b_fl), .id_ex_bubble(b_bub), .stall(b_st),
    .halted(b_h), .state(b_state), .cycle_cnt(b_cyc), .retire_cnt(b_ret),
    .stall_cnt(b_stl), .flush_cnt(b_flc));

  function automatic int bump(input int v, input int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  // Reference: one call per clock; returns what should be visible this cycle
  // and advances the model to the next cycle.
  task automatic step(input stim_t st, input int lat, input int mx,
                      inout mst_t m, output exp_t e);
    logic [1:0] src[2];
    bit         used[2];
    bit         hz, flush_ev;
    int         nmode;
    src[0] = st.id_rs1;  src[1] = st.id_rs2;
    used[0] = st.u1;     used[1] = st.u2;
    hz = 0;
    for (int i = 0; i < 2; i++) if (used[i] && src[i] == st.ex_rd) hz = 1;
    hz = hz && st.id_valid && st.ex_valid && st.ex_is_load && st.ex_reg_write;

    e.state = m.mode; e.cyc = m.cyc; e.ret = m.ret; e.stl = m.stl; e.fl = m.fl;
    e.chk = m.known; e.halted = 0; e.stall = 0;
    flush_ev = 0;
    nmode = m.mode;
    if (st.reset) begin
      {e.pc_en, e.if_id_en, e.flush, e.bubble} = 4'b0011;
      m.mode = 0; m.rem = 0; m.cyc = 0; m.ret = 0; m.stl = 0; m.fl = 0; m.known = 1;
      return;
    end
    if (m.mode == 0) begin
      {e.pc_en, e.if_id_en, e.flush, e.bubble} = 4'b1100;
      if (st.br) begin
        e.flush = 1; e.bubble = 1; flush_ev = 1;
      end else if (hz) begin
        e.pc_en = 0; e.if_id_en = 0; e.bubble = 1; e.stall = 1;
        m.rem = lat - 1;
        if (m.rem > 0) nmode = 1;
      end else if (st.halt) nmode = 2;
    end else if (m.mode == 1) begin
      {e.pc_en, e.if_id_en, e.flush, e.bubble} = 4'b0001;
      e.stall = 1;
      m.rem--;
      if (m.rem == 0) nmode = 0;
    end else if (m.mode == 2) begin
      {e.pc_en, e.if_id_en, e.flush, e.bubble} = 4'b0110;
      if (st.br) begin
        e.bubble = 1; flush_ev = 1;
      end else if (hz) begin
        e.flush = 0; e.if_id_en = 0; e.bubble = 1; e.stall = 1;
      end
      if (!st.id_valid && !st.ex_valid && !st.mem_valid) nmode = 3;
    end else begin
      {e.pc_en, e.if_id_en, e.flush, e.bubble} = 4'b0011;
      e.halted = 1;
    end
    if (st.clr) begin
      m.cyc = 0; m.ret = 0; m.stl = 0; m.fl = 0;
    end else begin
      if (m.mode != 3) m.cyc = bump(m.cyc, mx);
      if (st.retire)   m.ret = bump(m.ret, mx);
      if (e.stall)     m.stl = bump(m.stl, mx);
      if (flush_ev)    m.fl  = bump(m.fl, mx);
    end
    m.mode = nmode;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [5:0] ctl,
                     input logic [1:0] st_v, input logic [31:0] c0, input logic [31:0] c1,
                     input logic [31:0] c2, input logic [31:0] c3);
    chk({tag, ".pc_en"},        32'(ctl[5]), 32'(e.pc_en));
    chk({tag, ".if_id_en"},     32'(ctl[4]), 32'(e.if_id_en));
    chk({tag, ".if_id_flush"},  32'(ctl[3]), 32'(e.flush));
    chk({tag, ".id_ex_bubble"}, 32'(ctl[2]), 32'(e.bubble));
    chk({tag, ".stall"},        32'(ctl[1]), 32'(e.stall));
    chk({tag, ".halted"},       32'(ctl[0]), 32'(e.halted));
    if (e.chk) begin
      chk({tag, ".state"},      32'(st_v), e.state);
      chk({tag, ".cycle_cnt"},  c0, e.cyc);
      chk({tag, ".retire_cnt"}, c1, e.ret);
      chk({tag, ".stall_cnt"},  c2, e.stl);
      chk({tag, ".flush_cnt"},  c3, e.fl);
    end
  endtask

  // Monitor: every cycle's outputs are presented mid-cycle; pop and compare.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        cmp("A", ea, {a_pc, a_en, a_fl, a_bub, a_st, a_h}, a_state,
            32'(a_cyc), 32'(a_ret), 32'(a_stl), 32'(a_flc));
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        cmp("B", eb, {b_pc, b_en, b_fl, b_bub, b_st, b_h}, b_state,
            32'(b_cyc), 32'(b_ret), 32'(b_stl), 32'(b_flc));
      end
    end
  end

  task automatic cyc(input stim_t v);
    exp_t e;
    @(posedge clk);
    #1;
    s = v;
    step(v, 1, 65535, ma, e); qa.push_back(e);
    step(v, 3, 15, mb, e);    qb.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t v;
    v = '0;
    v.ex_reg_write = 1'b1;
    return v;
  endfunction

  function automatic stim_t load_use();
    stim_t v;
    v = idle();
    v.id_valid = 1; v.ex_valid = 1; v.ex_is_load = 1;
    v.ex_rd = 2'd2; v.id_rs2 = 2'd2; v.u2 = 1; v.id_rs1 = 2'd1; v.u1 = 1;
    return v;
  endfunction

  initial begin
    stim_t v;
    ma = '{default: 0}; mb = '{default: 0};
    s = '0;
    s.reset = 1'b1;
    // reset hold, then idle
    v = idle(); v.reset = 1;
    repeat (2) cyc(v);
    repeat (6) cyc(idle());
    // load-use hazard for one cycle
    cyc(load_use());
    repeat (4) cyc(idle());
    // branch together with a hazard
    v = load_use(); v.br = 1;
    cyc(v);
    repeat (2) cyc(idle());
    // halt with all stages valid, draining one stage per cycle
    v = idle(); v.halt = 1; v.id_valid = 1; v.ex_valid = 1; v.mem_valid = 1;
    cyc(v);
    v.id_valid = 0; v.retire = 1; cyc(v);
    v.ex_valid = 0; cyc(v);
    v.mem_valid = 0; cyc(v);
    v.retire = 0; repeat (3) cyc(v);
    v = idle(); v.reset = 1; cyc(v);
    // retire saturation, then clear wins over an increment
    v = idle(); v.retire = 1;
    repeat (20) cyc(v);
    v.clr = 1; cyc(v);
    repeat (2) cyc(idle());
    // reset in the middle of a load stall
    cyc(load_use());
    v = idle(); v.reset = 1; cyc(v);
    repeat (3) cyc(idle());
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v.reset        = ($urandom_range(63) == 0);
      v.id_valid     = ($urandom_range(3) != 0);
      v.id_rs1       = 2'($urandom_range(3));
      v.id_rs2       = 2'($urandom_range(3));
      v.u1           = $urandom_range(1);
      v.u2           = $urandom_range(1);
      v.ex_valid     = ($urandom_range(3) != 0);
      v.ex_rd        = 2'($urandom_range(3));
      v.ex_is_load   = $urandom_range(1);
      v.ex_reg_write = ($urandom_range(3) != 0);
      v.mem_valid    = ($urandom_range(3) != 0);
      v.br           = ($urandom_range(7) == 0);
      v.retire       = $urandom_range(1);
      v.halt         = ($urandom_range(39) == 0);
      v.clr          = ($urandom_range(31) == 0);
      cyc(v);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
